// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared opcode, field-encoding, FSM-state and control-word definitions
// for the ID-stage control decoder and its pipeline register.
package ctrl_decode_pipe_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
  localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
  localparam logic [OP_W-1:0] OP_LHU   = 6'b100101;
  localparam logic [OP_W-1:0] OP_LWU   = 6'b100111;
  localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
  localparam logic [OP_W-1:0] OP_SH    = 6'b101001;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_SLT    = 2'b11;

  localparam logic [1:0] WIDTH_WORD = 2'b11;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b00;

  localparam logic [1:0] ALUSRC_REG = 2'b00;
  localparam logic [1:0] ALUSRC_IMM = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       jump;
    logic       branch;
    logic       reg_dst;
    logic       mem2reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       sign_flag;
    logic       immediate;
    logic [1:0] alu_src;
    logic [1:0] alu_op;
    logic [1:0] width;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    jump: 1'b0, branch: 1'b0, reg_dst: 1'b0, mem2reg: 1'b0,
    reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
    sign_flag: 1'b0, immediate: 1'b0,
    alu_src: ALUSRC_REG, alu_op: ALUOP_ADD, width: WIDTH_WORD
  };

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// IF/ID-side inputs, EX-side hazard inputs and the registered control bundle.
interface ctrl_decode_pipe_if #(
  parameter int unsigned NB_INSTR = 32,
  parameter int unsigned NB_REG   = 5
);
  logic                i_valid;
  logic [NB_INSTR-1:0] i_instr;
  logic                i_ex_memRead;
  logic [NB_REG-1:0]   i_ex_rt;
  logic                i_flush;
  logic                i_resume;
  logic                o_stall;
  logic                o_valid;
  logic                o_jump;
  logic                o_branch;
  logic                o_regDst;
  logic                o_mem2Reg;
  logic                o_regWrite;
  logic                o_memRead;
  logic                o_memWrite;
  logic                o_sign_flag;
  logic                o_immediate;
  logic [1:0]          o_aluSrc;
  logic [1:0]          o_aluOp;
  logic [1:0]          o_width;
  logic                o_illegal;
  logic                o_halted;

  modport master (
    output i_valid, i_instr, i_ex_memRead, i_ex_rt, i_flush, i_resume,
    input  o_stall, o_valid, o_jump, o_branch, o_regDst, o_mem2Reg, o_regWrite,
           o_memRead, o_memWrite, o_sign_flag, o_immediate, o_aluSrc, o_aluOp,
           o_width, o_illegal, o_halted
  );

  modport slave (
    input  i_valid, i_instr, i_ex_memRead, i_ex_rt, i_flush, i_resume,
    output o_stall, o_valid, o_jump, o_branch, o_regDst, o_mem2Reg, o_regWrite,
           o_memRead, o_memWrite, o_sign_flag, o_immediate, o_aluSrc, o_aluOp,
           o_width, o_illegal, o_halted
  );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure opcode-to-control lookup with illegal-opcode and rt-source flags.
module ctrl_decode_comb
  import ctrl_decode_pipe_pkg::*;
#(
  parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl,
  output logic            illegal,
  output logic            uses_rt
);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    illegal = 1'b0;
    uses_rt = 1'b0;
    if (opcode == HALT_OP) begin
      ctrl.width = WIDTH_BYTE;  // HALT carries an all-zero word
    end else begin
      case (opcode)
        OP_RTYPE: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_RTYPE;
          uses_rt        = 1'b1;
        end
        OP_LW, OP_LWU, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
          ctrl.alu_src   = ALUSRC_IMM;
          ctrl.mem2reg   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.mem_read  = 1'b1;
          ctrl.sign_flag = (opcode == OP_LWU) || (opcode == OP_LHU) || (opcode == OP_LBU);
          if ((opcode == OP_LH) || (opcode == OP_LHU))      ctrl.width = WIDTH_HALF;
          else if ((opcode == OP_LB) || (opcode == OP_LBU)) ctrl.width = WIDTH_BYTE;
          else                                              ctrl.width = WIDTH_WORD;
        end
        OP_SW, OP_SH, OP_SB: begin
          ctrl.alu_src   = ALUSRC_IMM;
          ctrl.mem_write = 1'b1;
          uses_rt        = 1'b1;
          if (opcode == OP_SH)      ctrl.width = WIDTH_HALF;
          else if (opcode == OP_SB) ctrl.width = WIDTH_BYTE;
          else                      ctrl.width = WIDTH_WORD;
        end
        OP_BEQ, OP_BNE: begin
          ctrl.branch = 1'b1;
          ctrl.alu_op = ALUOP_BRANCH;
          uses_rt     = 1'b1;
        end
        OP_ADDI: begin
          ctrl.alu_src   = ALUSRC_IMM;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        OP_ORI, OP_XORI: begin
          ctrl.alu_src   = ALUSRC_IMM;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_BRANCH;
          ctrl.immediate = 1'b1;
        end
        OP_SLTI: begin
          ctrl.alu_src   = ALUSRC_IMM;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_SLT;
          ctrl.immediate = 1'b1;
        end
        OP_LUI: begin
          ctrl.alu_src   = ALUSRC_IMM;
          ctrl.reg_write = 1'b1;
          ctrl.immediate = 1'b1;
          ctrl.sign_flag = 1'b1;
        end
        OP_J: begin
          ctrl.jump = 1'b1;
        end
        OP_JAL: begin
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID-stage control decode with load-use stall, flush, HALT drain FSM and
// the control half of the ID/EX pipeline register.
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int unsigned      NB_OP        = 6,
  parameter int unsigned      NB_REG       = 5,
  parameter int unsigned      NB_INSTR     = 32,
  parameter int unsigned      DRAIN_CYCLES = 4,
  parameter logic [NB_OP-1:0] HALT_OP      = '1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  ctrl_decode_pipe_if.slave bus
);

  localparam int unsigned RS_LSB = NB_INSTR - NB_OP - NB_REG;
  localparam int unsigned RT_LSB = RS_LSB - NB_REG;

  logic [NB_OP-1:0]  opcode;
  logic [NB_REG-1:0] rs;
  logic [NB_REG-1:0] rt;
  logic              unused_low_bits;

  assign opcode          = bus.i_instr[NB_INSTR-1 -: NB_OP];
  assign rs              = bus.i_instr[RS_LSB +: NB_REG];
  assign rt              = bus.i_instr[RT_LSB +: NB_REG];
  assign unused_low_bits = ^bus.i_instr[RT_LSB-1:0];

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  logic  dec_uses_rt;
  logic  uses_rs;
  logic  is_halt;
  logic  hazard;

  ctrl_decode_comb #(.HALT_OP(OP_W'(HALT_OP))) u_dec (
    .opcode  (OP_W'(opcode)),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .uses_rt (dec_uses_rt)
  );

  // rs is a source for everything except the jumps and LUI
  assign uses_rs = !((OP_W'(opcode) == OP_J) || (OP_W'(opcode) == OP_JAL) ||
                     (OP_W'(opcode) == OP_LUI));
  assign is_halt = (opcode == HALT_OP);
  assign hazard  = bus.i_valid && bus.i_ex_memRead && (bus.i_ex_rt != '0) &&
                   ((uses_rs && (rs == bus.i_ex_rt)) ||
                    (dec_uses_rt && (rt == bus.i_ex_rt)));

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  ctrl_t            ctrl_q, ctrl_nxt;
  logic             valid_q, valid_nxt;
  logic             illegal_q, illegal_nxt;
  logic             halted_q;
  logic             stall_c;

  // next-state, stall and next control word; flush outranks stall
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    ctrl_nxt    = CTRL_BUBBLE;
    valid_nxt   = 1'b0;
    illegal_nxt = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall_c = hazard && !bus.i_flush;
        if (bus.i_valid && !bus.i_flush && !hazard) begin
          if (is_halt) begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
          end else begin
            ctrl_nxt    = dec_ctrl;
            valid_nxt   = 1'b1;
            illegal_nxt = dec_illegal;
          end
        end
      end
      ST_DRAIN: begin
        stall_c = 1'b1;
        if (cnt_q == '0) state_nxt = ST_HALTED;
        else             cnt_nxt   = cnt_q - CNT_W'(1);
      end
      ST_HALTED: begin
        stall_c = 1'b1;
        if (bus.i_resume) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ctrl_q    <= CTRL_BUBBLE;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      ctrl_q    <= ctrl_nxt;
      valid_q   <= valid_nxt;
      illegal_q <= illegal_nxt;
      halted_q  <= (state_nxt == ST_HALTED);
    end
  end

  assign bus.o_stall     = stall_c;
  assign bus.o_valid     = valid_q;
  assign bus.o_jump      = ctrl_q.jump;
  assign bus.o_branch    = ctrl_q.branch;
  assign bus.o_regDst    = ctrl_q.reg_dst;
  assign bus.o_mem2Reg   = ctrl_q.mem2reg;
  assign bus.o_regWrite  = ctrl_q.reg_write;
  assign bus.o_memRead   = ctrl_q.mem_read;
  assign bus.o_memWrite  = ctrl_q.mem_write;
  assign bus.o_sign_flag = ctrl_q.sign_flag;
  assign bus.o_immediate = ctrl_q.immediate;
  assign bus.o_aluSrc    = ctrl_q.alu_src;
  assign bus.o_aluOp     = ctrl_q.alu_op;
  assign bus.o_width     = ctrl_q.width;
  assign bus.o_illegal   = illegal_q;
  assign bus.o_halted    = halted_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench: directed scenarios then random traffic, all checked
// against a table-driven reference model of decode, hazards and HALT timing.
module tb_ctrl_decode_pipe;

  localparam int unsigned DRAIN = 4;
  localparam logic [5:0]  HALT  = 6'b111111;
  localparam logic [14:0] BUB   = 15'b000000000_00_00_11;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ctrl_decode_pipe_if #(.NB_INSTR(32), .NB_REG(5)) bus ();

  ctrl_decode_pipe #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [5:0] ops [19] = '{6'b000000, 6'b100011, 6'b100111, 6'b100001, 6'b100101,
                           6'b100000, 6'b100100, 6'b101011, 6'b101001, 6'b101000,
                           6'b000100, 6'b000101, 6'b001000, 6'b001101, 6'b001110,
                           6'b001010, 6'b001111, 6'b000010, 6'b000011};

  // model state: 0 run, 1 drain, 2 halted; left = edges until halted
  int          mode;
  int          left;
  logic [14:0] e_ctrl;
  logic        e_valid;
  logic        e_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {jump,branch,regDst,mem2Reg,regWrite,memRead,memWrite,sign,imm,aluSrc,aluOp,width}
  function automatic logic [14:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'b000000: return 15'b001010000_00_10_11;
      6'b100011: return 15'b000111000_01_00_11;
      6'b100111: return 15'b000111010_01_00_11;
      6'b100001: return 15'b000111000_01_00_01;
      6'b100101: return 15'b000111010_01_00_01;
      6'b100000: return 15'b000111000_01_00_00;
      6'b100100: return 15'b000111010_01_00_00;
      6'b101011: return 15'b000000100_01_00_11;
      6'b101001: return 15'b000000100_01_00_01;
      6'b101000: return 15'b000000100_01_00_00;
      6'b000100: return 15'b010000000_00_01_11;
      6'b000101: return 15'b010000000_00_01_11;
      6'b001000: return 15'b000010000_01_00_11;
      6'b001101: return 15'b000010001_01_01_11;
      6'b001110: return 15'b000010001_01_01_11;
      6'b001010: return 15'b000010001_01_11_11;
      6'b001111: return 15'b000010011_01_00_11;
      6'b000010: return 15'b100000000_00_00_11;
      6'b000011: return 15'b100010000_00_00_11;
      default:   return BUB;
    endcase
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return (op inside {ops}) || (op == HALT);
  endfunction

  function automatic logic src_rs(input logic [5:0] op);
    return !(op inside {6'b000010, 6'b000011, 6'b001111});
  endfunction

  function automatic logic src_rt(input logic [5:0] op);
    return op inside {6'b000000, 6'b101011, 6'b101001, 6'b101000, 6'b000100, 6'b000101};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'($urandom)};
  endfunction

  task automatic check_outputs(input string tag);
    logic [14:0] got;
    got = {bus.o_jump, bus.o_branch, bus.o_regDst, bus.o_mem2Reg, bus.o_regWrite,
           bus.o_memRead, bus.o_memWrite, bus.o_sign_flag, bus.o_immediate,
           bus.o_aluSrc, bus.o_aluOp, bus.o_width};
    check({tag, ".valid"},   32'(bus.o_valid),   32'(e_valid));
    check({tag, ".ctrl"},    32'(got),           32'(e_ctrl));
    check({tag, ".illegal"}, 32'(bus.o_illegal), 32'(e_ill));
    check({tag, ".halted"},  32'(bus.o_halted),  32'(mode == 2));
  endtask

  // one ID cycle: drive, check stall before the edge, check registers after it
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic mr, input logic [4:0] ert, input logic fl, input logic res);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       hz, acc, st;
    bus.i_valid = v; bus.i_instr = ins; bus.i_ex_memRead = mr;
    bus.i_ex_rt = ert; bus.i_flush = fl; bus.i_resume = res;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    hz = v && mr && (ert != 0) && ((src_rs(op) && rs == ert) || (src_rt(op) && rt == ert));
    if (mode == 0) begin st = hz && !fl; acc = v && !fl && !hz; end
    else begin st = 1'b1; acc = 1'b0; end
    @(negedge clk);
    check({tag, ".stall"}, 32'(bus.o_stall), 32'(st));
    e_ctrl = BUB; e_valid = 1'b0; e_ill = 1'b0;
    if (acc && op != HALT) begin
      e_ctrl = ref_ctrl(op); e_valid = 1'b1; e_ill = !legal(op);
    end
    if (mode == 0 && acc && op == HALT) begin
      mode = 1; left = DRAIN;
    end else if (mode == 1) begin
      left--;
      if (left == 0) mode = 2;
    end else if (mode == 2 && res) begin
      mode = 0;
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [5:0] op;
    int         r;
    total = 0; bad = 0; mode = 0; left = 0;
    e_ctrl = BUB; e_valid = 1'b0; e_ill = 1'b0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_ex_memRead = 1'b0;
    bus.i_ex_rt = '0; bus.i_flush = 1'b0; bus.i_resume = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    step("lw",       1'b1, mk(6'b100011, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0);
    step("lu_stall", 1'b1, mk(6'b000000, 5'd3, 5'd5), 1'b1, 5'd5, 1'b0, 1'b0);
    step("lu_go",    1'b1, mk(6'b000000, 5'd3, 5'd5), 1'b0, 5'd0, 1'b0, 1'b0);
    step("lu_r0",    1'b1, mk(6'b000000, 5'd0, 5'd0), 1'b1, 5'd0, 1'b0, 1'b0);
    step("lu_flush", 1'b1, mk(6'b000000, 5'd3, 5'd5), 1'b1, 5'd5, 1'b1, 1'b0);
    step("illegal",  1'b1, mk(6'b010011, 5'd1, 5'd1), 1'b0, 5'd0, 1'b0, 1'b0);
    step("idle",     1'b0, mk(6'b000000, 5'd4, 5'd4), 1'b1, 5'd4, 1'b0, 1'b0);
    step("halt",     1'b1, mk(HALT, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      step("drain", 1'b1, mk(6'b001000, 5'd1, 5'd2), 1'b0, 5'd0, i == 1, 1'b0);
    step("resume",   1'b1, mk(6'b001000, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b1);
    step("after",    1'b1, mk(6'b101011, 5'd1, 5'd2), 1'b0, 5'd0, 1'b0, 1'b0);

    // asynchronous reset while draining
    step("halt2",    1'b1, mk(HALT, 5'd0, 5'd0), 1'b0, 5'd0, 1'b0, 1'b0);
    step("drain2",   1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mode = 0; left = 0; e_ctrl = BUB; e_valid = 1'b0; e_ill = 1'b0;
    check_outputs("async_rst");
    check("async_rst.stall", 32'(bus.o_stall), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    step("post_rst", 1'b1, mk(6'b000011, 5'd7, 5'd7), 1'b1, 5'd7, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       op = HALT;
      else if (r < 12) op = 6'($urandom);
      else             op = ops[$urandom_range(0, 18)];
      step("rand", ($urandom_range(0, 9) != 0),
           mk(op, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 5)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
